// File: rtl/piso_pkg.sv
// piso_pkg: shared types for the PISO serializer.
//   STATE_W  - width of the serializer state encoding
//   state_t  - serializer states (IDLE, SHIFT, PARITY, DONE)
package piso_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: bit-position counter for the PISO serializer.
//   clk, reset (async, active-high), en (clock enable)
//   clear  - zero the counter on the next enabled edge (has priority)
//   inc    - advance the counter on the next enabled edge
//   last_c - combinational flag: counter is on the final bit (WIDTH-1)
module piso_bit_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    input  logic inc,
    output logic last_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] count;

    // Saturating guard keeps the count within 0..WIDTH even if inc is misused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            if (clear) begin
                count <= '0;
            end else if (inc && (count < CNT_W'(WIDTH))) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign last_c = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out word serializer.
//   Parameters: WIDTH (bits per word, 2..32), MSB_FIRST (1: MSB first, 0: LSB first)
//   Inputs : clk, reset (async, active-high), en (clock enable),
//            load_valid, load_data[WIDTH-1:0]
//   Outputs: load_ready (IDLE only), sout, sout_valid, busy (not IDLE),
//            done (one enabled cycle at end of word)
//   Optional: define PISO_PARITY_EN to append an even-parity bit after the data.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic             accept_c;
    logic             cnt_inc_c;
    logic             cnt_last_c;
`ifdef PISO_PARITY_EN
    logic             parity_q;
`endif

    // Bit that leaves the word first for the configured order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        head_bit = MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign accept_c  = (state == IDLE) && load_valid;
    assign cnt_inc_c = (state == SHIFT) && !cnt_last_c;

    // Rotate so the next bit to send sits at the head position.
    always_comb begin
        if (MSB_FIRST) begin
            shreg_next = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
        end else begin
            shreg_next = {shreg[0], shreg[WIDTH-1:1]};
        end
    end

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .clear  (accept_c),
        .inc    (cnt_inc_c),
        .last_c (cnt_last_c)
    );

    // Serializer FSM; the counter holds the index of the bit now on sout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef PISO_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        state      <= SHIFT;
                        shreg      <= load_data;
                        sout       <= head_bit(load_data);
                        sout_valid <= 1'b1;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
`ifdef PISO_PARITY_EN
                        parity_q   <= ^load_data;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt_last_c) begin
`ifdef PISO_PARITY_EN
                        state      <= PARITY;
                        sout       <= parity_q;
                        sout_valid <= 1'b1;
`else
                        state      <= DONE;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        done       <= 1'b1;
`endif
                    end else begin
                        shreg <= shreg_next;
                        sout  <= head_bit(shreg_next);
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    state      <= DONE;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    done       <= 1'b1;
                end
`endif
                DONE: begin
                    state      <= IDLE;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning the number of data bits per word (legal range 2..32).
REQ-002 SHALL provide parameter MSB_FIRST, default 1, meaning 1 shifts the MSB out first and 0 shifts the LSB out first.
REQ-003 SHALL provide clk  input  1  rising-edge clock.
REQ-004 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide en  input  1  clock enable; while low, all state is frozen.
REQ-006 SHALL provide load_valid  input  1  a parallel word is offered.
REQ-007 SHALL provide load_data  input  WIDTH  the parallel word.
REQ-008 SHALL provide load_ready  output  1  the block can accept a word.
REQ-009 SHALL provide sout  output  1  serial data bit, registered.
REQ-010 SHALL provide sout_valid  output  1  sout carries a valid bit this cycle.
REQ-011 SHALL provide busy  output  1  high in any state other than IDLE.
REQ-012 SHALL provide done  output  1  one-cycle end-of-word pulse.

Function
REQ-013 SHALL implement states IDLE, SHIFT, PARITY and DONE.
REQ-014 SHALL evaluate all transitions and register updates only on a rising clk edge with en=1.
REQ-015 SHALL drive load_ready=1 only in IDLE.
REQ-016 SHALL accept a word on an edge with load_valid=1, load_ready=1 and en=1: capture load_data into the shift register, clear the bit counter and go to SHIFT.
REQ-017 SHALL, in SHIFT, present bit k of the word on sout with sout_valid=1 for one enabled cycle each, k=0..WIDTH-1 in the order set by MSB_FIRST; the first bit appears in the cycle after acceptance.
REQ-018 SHALL leave SHIFT after WIDTH enabled cycles, going to PARITY if the parity feature is compiled in and to DONE otherwise.
REQ-019 SHALL, in DONE, drive done=1, sout=0, sout_valid=0 and busy=1 for exactly one enabled cycle, then return to IDLE.
REQ-020 SHALL ignore load_valid in SHIFT, PARITY and DONE, with no capture and no effect on the word in flight.
REQ-021 SHALL, with en=0 for any number of cycles, hold state, counter, shift register and every output; done therefore stays high while frozen in DONE.
REQ-022 SHALL drive sout=0 and sout_valid=0 in IDLE.
REQ-023 SHALL size the bit counter as $clog2(WIDTH+1) bits and never let it exceed WIDTH.

Reset
REQ-024 SHALL, on reset high and regardless of clk or en, force state=IDLE, counter=0, shift register=0, sout=0, sout_valid=0, done=0, busy=0 and load_ready=1.
REQ-025 SHALL abort a word in progress when reset is asserted mid-word, with no done pulse and no remaining bits emitted.
REQ-026 SHALL be able to accept a new word on the first enabled edge after reset is released.

Configuration
REQ-027 SHALL compile the parity stage in only when PISO_PARITY_EN is defined.
REQ-028 SHALL, with PISO_PARITY_EN defined, spend one PARITY cycle after SHIFT with sout equal to the even parity (XOR) of the captured word and sout_valid=1.
REQ-029 SHALL, without PISO_PARITY_EN, contain no PARITY state logic and go directly SHIFT->DONE; total busy time is WIDTH+1 enabled cycles.

Structure
REQ-030 SHALL take the state enum type state_t (IDLE, SHIFT, PARITY, DONE) and its width constant from the shared package piso_pkg.
REQ-031 SHALL implement the bit counter (with clear, increment-on-enable and terminal-count flag) as the sub-module piso_bit_cnt, using the same clk/reset/en ports.

Verification
REQ-032 SHALL cover: WIDTH=8, MSB_FIRST=1, load 0xA5 with en=1 -> sout 1,0,1,0,0,1,0,1 on cycles 1-8, done=1 on cycle 9, load_ready=1 on cycle 10.
REQ-033 SHALL cover: MSB_FIRST=0, load 0xA5 -> sout 1,0,1,0,0,1,0,1 (LSB first, symmetric word); then load 0x01 -> 1,0,0,0,0,0,0,0.
REQ-034 SHALL cover: load 0xF0, drop en for 3 cycles after bit 2 -> sout, sout_valid and the counter hold; the remaining bits resume unchanged and done appears 3 cycles later than the nominal cycle.
REQ-035 SHALL cover: reset pulse during bit 4 of 0xFF -> all outputs 0 and load_ready=1 immediately, with no done pulse.
REQ-036 SHALL cover: load_valid=1 with 0x3C held throughout the shifting of 0xC3 -> the stream is exactly 0xC3 and 0x3C is accepted only in IDLE.
REQ-037 SHALL cover: with PISO_PARITY_EN defined, load 0x07 -> 8 data bits, then parity bit 1 on cycle 9, then done on cycle 10.
